// File: rtl/cipher_pkg.sv
// Shared types and reset-time key material for the permute/XOR round cipher.
package cipher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] KEY_DEF_0 = 8'h3E;
  localparam logic [7:0] KEY_DEF_1 = 8'h49;
  localparam logic [7:0] KEY_DEF_2 = 8'h7E;

  // Default round key for slot idx: the three constants repeat, zero-extended.
  function automatic logic [63:0] default_key(input int idx);
    logic [7:0] k;
    case (idx % 3)
      0:       k = KEY_DEF_0;
      1:       k = KEY_DEF_1;
      default: k = KEY_DEF_2;
    endcase
    return {56'd0, k};
  endfunction

endpackage

// File: rtl/perm_net.sv
// Combinational stride bit permutation; inv selects the inverse mapping.
module perm_net #(
  parameter int N      = 8,
  parameter int STRIDE = 3
) (
  input  logic [N-1:0] x,
  input  logic         inv,
  output logic [N-1:0] y
);

  logic [N-1:0] fwd;
  logic [N-1:0] bwd;

  // STRIDE odd and N a power of two make i*STRIDE mod N a bijection,
  // so every bit of bwd gets exactly one driver.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign fwd[i]              = x[(i*STRIDE) % N];
    assign bwd[(i*STRIDE) % N] = x[i];
  end

  assign y = inv ? bwd : fwd;

endmodule

// File: rtl/perm_xor_cipher.sv
// Iterative permute/XOR block cipher: one round per cycle, per-round key registers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a word; key writes accepted
// ST_RUN  | applying rounds, one per cycle, then one cycle to settle
// ST_DONE | result held on dout until out_ready
module perm_xor_cipher
  import cipher_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int STRIDE = 3,
  parameter  int ROUNDS = 3,
  localparam int KW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  din,
  input  logic          mode,
  input  logic          key_we,
  input  logic [KW-1:0] key_idx,
  input  logic [N-1:0]  key_din,
  output logic          key_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  dout
);

  localparam int CW = $clog2(ROUNDS + 1);

  state_t        state;
  state_t        state_nxt;
  logic          alive;
  logic [CW-1:0] cnt;
  logic          mode_q;
  logic [N-1:0]  data_q;
  logic [N-1:0]  dout_q;
  logic [N-1:0]  key_q    [ROUNDS];
  logic [N-1:0]  key_work [ROUNDS];

  logic          accept;
  logic          round_en;
  logic          finish;
  logic          key_ok;
  logic          key_drop;
  logic [31:0]   key_idx_ext;
  logic [CW-1:0] rsel;
  logic [N-1:0]  rkey;
  logic [N-1:0]  perm_in;
  logic [N-1:0]  perm_out;
  logic [N-1:0]  round_out;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    round_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = alive;
        if (alive && in_valid) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == CW'(ROUNDS)) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          round_en = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign key_idx_ext = 32'(key_idx);
  assign key_ok      = key_we && (state == ST_IDLE) && (key_idx_ext < 32'(ROUNDS));
  assign key_drop    = key_we && !key_ok;

  // Decrypt walks the key schedule backwards.
  assign rsel = mode_q ? (CW'(ROUNDS - 1) - cnt) : cnt;

  always_comb begin
    rkey = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      if (rsel == CW'(r)) rkey = key_work[r];
    end
  end

  assign perm_in   = mode_q ? (data_q ^ rkey) : data_q;
  assign round_out = mode_q ? perm_out : (perm_out ^ rkey);

  perm_net #(
    .N      (N),
    .STRIDE (STRIDE)
  ) u_perm (
    .x   (perm_in),
    .inv (mode_q),
    .y   (perm_out)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      alive   <= 1'b0;
      cnt     <= '0;
      mode_q  <= 1'b0;
      data_q  <= '0;
      dout_q  <= '0;
      key_err <= 1'b0;
    end else begin
      alive   <= 1'b1;
      key_err <= key_drop;
      if (accept) begin
        data_q <= din;
        mode_q <= mode;
        cnt    <= '0;
      end else if (round_en) begin
        data_q <= round_out;
        cnt    <= cnt + CW'(1);
      end
      if (finish) dout_q <= data_q;
    end
  end

  // The working copy is snapshotted on accept so a key write at the
  // same edge only affects later words.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROUNDS; r++) begin
        key_q[r]    <= N'(default_key(r));
        key_work[r] <= '0;
      end
    end else begin
      for (int r = 0; r < ROUNDS; r++) begin
        if (key_ok && (key_idx == KW'(r))) key_q[r] <= key_din;
        if (accept) key_work[r] <= key_q[r];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_perm_xor_cipher.sv
// Directed scoreboard bench: a 1-round and a 3-round instance checked against a bit-level model.
module tb_perm_xor_cipher;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  logic       in_valid_1 = 0, in_ready_1, mode_1 = 0, key_we_1 = 0, key_err_1;
  logic       out_valid_1, out_ready_1 = 0;
  logic [0:0] key_idx_1 = '0;
  logic [7:0] din_1 = '0, key_din_1 = '0, dout_1;

  logic       in_valid_3 = 0, in_ready_3, mode_3 = 0, key_we_3 = 0, key_err_3;
  logic       out_valid_3, out_ready_3 = 0;
  logic [1:0] key_idx_3 = '0;
  logic [7:0] din_3 = '0, key_din_3 = '0, dout_3;

  perm_xor_cipher #(.N(8), .STRIDE(3), .ROUNDS(1)) dut_r1 (
    .clock(clock), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .din(din_1), .mode(mode_1), .key_we(key_we_1), .key_idx(key_idx_1),
    .key_din(key_din_1), .key_err(key_err_1), .out_valid(out_valid_1),
    .out_ready(out_ready_1), .dout(dout_1)
  );

  perm_xor_cipher #(.N(8), .STRIDE(3), .ROUNDS(3)) dut_r3 (
    .clock(clock), .rst(rst), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .din(din_3), .mode(mode_3), .key_we(key_we_3), .key_idx(key_idx_3),
    .key_din(key_din_3), .key_err(key_err_3), .out_valid(out_valid_3),
    .out_ready(out_ready_3), .dout(dout_3)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mk1 [3];
  logic [7:0] mk3 [3];
  logic [7:0] enc_a5;

  function automatic logic [7:0] perm(input logic [7:0] x, input bit inv);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      if (!inv) y[i] = x[(i*3) % 8];
      else      y[(i*3) % 8] = x[i];
    end
    return y;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] d, input bit m,
                                       input int rounds, input logic [7:0] k [3]);
    logic [7:0] x;
    x = d;
    if (!m) for (int r = 0; r < rounds; r++) x = perm(x, 1'b0) ^ k[r];
    else    for (int r = rounds - 1; r >= 0; r--) x = perm(x ^ k[r], 1'b1);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    mk1 = '{8'h3E, 8'h49, 8'h7E};
    mk3 = '{8'h3E, 8'h49, 8'h7E};
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic push_word(input bit d3, input logic [7:0] d, input bit m,
                           input int exp, input bit keep);
    int n;
    logic [7:0] e;
    n = 0;
    while (!(d3 ? in_ready_3 : in_ready_1) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    if (d3) begin in_valid_3 = 1; din_3 = d; mode_3 = m; end
    else    begin in_valid_1 = 1; din_1 = d; mode_1 = m; end
    if (exp >= 0)  e = exp[7:0];
    else if (d3)   e = model(d, m, 3, mk3);
    else           e = model(d, m, 1, mk1);
    if (keep) exp_q.push_back(e);
    @(negedge clock);
    in_valid_1 = 0;
    in_valid_3 = 0;
  endtask

  task automatic pop_check(input bit d3, input int exp_lat, input int hold, input string tag);
    int lat;
    logic [7:0] e, held;
    lat = 0;
    while (!(d3 ? out_valid_3 : out_valid_1) && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_valid_wait"}, 32'(lat < 50), 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    held = d3 ? dout_3 : dout_1;
    chk({tag, "_dout"}, 32'(held), 32'(e));
    for (int i = 0; i < hold; i++) begin
      // Offer a competing word while DONE; it must be ignored.
      if (d3) begin in_valid_3 = 1; din_3 = ~held; end
      else    begin in_valid_1 = 1; din_1 = ~held; end
      @(negedge clock);
      chk({tag, "_hold_valid"}, 32'(d3 ? out_valid_3 : out_valid_1), 32'd1);
      chk({tag, "_hold_dout"}, 32'(d3 ? dout_3 : dout_1), 32'(held));
      chk({tag, "_hold_ready"}, 32'(d3 ? in_ready_3 : in_ready_1), 32'd0);
    end
    in_valid_1 = 0;
    in_valid_3 = 0;
    if (d3) out_ready_3 = 1; else out_ready_1 = 1;
    @(negedge clock);
    out_ready_1 = 0;
    out_ready_3 = 0;
    chk({tag, "_consumed"}, 32'(d3 ? out_valid_3 : out_valid_1), 32'd0);
  endtask

  task automatic key_write(input bit d3, input int idx, input logic [7:0] v,
                           input bit exp_err, input string tag);
    if (d3) begin key_we_3 = 1; key_idx_3 = idx[1:0]; key_din_3 = v; end
    else    begin key_we_1 = 1; key_idx_1 = idx[0:0]; key_din_1 = v; end
    @(negedge clock);
    key_we_1 = 0;
    key_we_3 = 0;
    chk({tag, "_err"}, 32'(d3 ? key_err_3 : key_err_1), 32'(exp_err));
    if (!exp_err) begin
      if (d3) mk3[idx] = v; else mk1[idx] = v;
    end
    @(negedge clock);
    chk({tag, "_err_pulse"}, 32'(d3 ? key_err_3 : key_err_1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    repeat (2) @(negedge clock);
    chk("rst_in_ready_r3", 32'(in_ready_3), 32'd0);
    chk("rst_in_ready_r1", 32'(in_ready_1), 32'd0);
    chk("rst_out_valid", 32'(out_valid_3), 32'd0);
    chk("rst_key_err", 32'(key_err_3), 32'd0);
    chk("rst_dout", 32'(dout_3), 32'd0);
    rst = 1;
    @(negedge clock);
    chk("post_rst_in_ready", 32'(in_ready_3), 32'd1);

    // One-round vectors with the default key.
    push_word(0, 8'h02, 0, 8'h36, 1);
    pop_check(0, 2, 0, "r1_enc");
    push_word(0, 8'h36, 1, 8'h02, 1);
    pop_check(0, 2, 0, "r1_dec");

    // Three rounds, default keys, round trip.
    enc_a5 = model(8'hA5, 0, 3, mk3);
    push_word(1, 8'hA5, 0, -1, 1);
    pop_check(1, 4, 0, "r3_enc");
    push_word(1, enc_a5, 1, 8'hA5, 1);
    pop_check(1, 4, 0, "r3_dec");

    push_word(1, 8'h3C, 0, -1, 1);
    pop_check(1, 4, 5, "hold");

    // Dropped key writes: out-of-range index, and a write during RUN.
    key_write(1, 3, 8'hFF, 1, "kidx_range");
    push_word(1, 8'h5A, 0, -1, 1);
    key_write(1, 0, 8'hAA, 1, "kwe_run");
    pop_check(1, -1, 0, "run_key");
    push_word(1, 8'h5A, 0, -1, 1);
    pop_check(1, 4, 0, "key_unchanged");

    // All-zero keys leave only the permutation.
    key_write(1, 0, 8'h00, 0, "kz0");
    key_write(1, 1, 8'h00, 0, "kz1");
    key_write(1, 2, 8'h00, 0, "kz2");
    push_word(1, 8'h02, 0, 8'h08, 1);
    pop_check(1, 4, 0, "zero_enc");
    push_word(1, 8'h08, 1, 8'h02, 1);
    pop_check(1, 4, 0, "zero_dec");

    // Key write coinciding with accept: that word keeps the old key.
    in_valid_3 = 1; din_3 = 8'h5A; mode_3 = 0;
    key_we_3 = 1; key_idx_3 = 2'd0; key_din_3 = 8'hC3;
    exp_q.push_back(model(8'h5A, 0, 3, mk3));
    @(negedge clock);
    in_valid_3 = 0;
    key_we_3 = 0;
    chk("same_edge_err", 32'(key_err_3), 32'd0);
    mk3[0] = 8'hC3;
    pop_check(1, -1, 0, "same_edge_old");
    push_word(1, 8'h5A, 0, -1, 1);
    pop_check(1, 4, 0, "same_edge_new");

    // Reset mid-RUN aborts the word and restores default keys.
    push_word(1, 8'h77, 0, -1, 0);
    rst = 0;
    #1;
    chk("midrun_rst_ready", 32'(in_ready_3), 32'd0);
    @(negedge clock);
    chk("midrun_rst_valid", 32'(out_valid_3), 32'd0);
    rst = 1;
    reset_model();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("midrun_no_output", 32'(out_valid_3), 32'd0);
    end
    push_word(1, 8'h02, 0, -1, 1);
    pop_check(1, 4, 0, "post_reset");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perm_xor_cipher.md
PERM_XOR_CIPHER -- requirements
Module: perm_xor_cipher

Interface
REQ-001 Parameter N, default 8: data/key width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter STRIDE, default 3: permutation stride; SHALL be odd and less than N.
REQ-003 Parameter ROUNDS, default 3: round count, 1..16.
REQ-004 clock  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  input word offered.
REQ-007 in_ready  out  1  block can accept a word.
REQ-008 din  in  N  plaintext (encrypt) or ciphertext (decrypt).
REQ-009 mode  in  1  0 = encrypt, 1 = decrypt; sampled with din at the input handshake.
REQ-010 key_we  in  1  key write strobe.
REQ-011 key_idx  in  clog2(ROUNDS) (min 1)  round-key index.
REQ-012 key_din  in  N  round-key value.
REQ-013 key_err  out  1  one-cycle pulse: key write dropped.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 dout  out  N  result word.

Function
REQ-017 Forward permutation P(x): out[i] = x[(i*STRIDE) mod N]; inverse Pinv(y): out[(i*STRIDE) mod N] = y[i].
REQ-018 Encrypt: x = P(x) ^ K[r], for r = 0..ROUNDS-1 in order.
REQ-019 Decrypt: x = Pinv(x ^ K[r]), for r = ROUNDS-1 down to 0; decrypt(encrypt(d)) SHALL equal d.
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 IDLE: in_ready = 1; in_valid = 1 latches din and mode, clears round counter, and moves to RUN.
REQ-022 RUN: exactly one round per cycle; after the ROUNDS-th round the FSM moves to DONE.
REQ-023 Latency: handshake at edge E0 gives out_valid = 1 from edge E0+ROUNDS+1 onward.
REQ-024 DONE: out_valid = 1 and dout stable until out_valid & out_ready; then the FSM returns to IDLE. No same-cycle re-accept.
REQ-025 in_ready = 0 in RUN and DONE; in_valid in those states SHALL be ignored.
REQ-026 key_we in IDLE writes K[key_idx] at that edge; the new key is used by the next accepted word.
REQ-027 key_we in RUN or DONE: write dropped; key_err pulses high for one cycle.
REQ-028 key_idx >= ROUNDS: write dropped; key_err pulses.
REQ-029 key_we and input handshake at the same IDLE edge: the key is written; the accepted word uses the old key.
REQ-030 Round counter SHALL not wrap; it is cleared only on accept.

Reset
REQ-031 Reset values: in_ready = 0 during reset and 1 after release; out_valid = 0; key_err = 0; dout = 0; FSM = IDLE; counter = 0.
REQ-032 Key registers reset to the package defaults: 0x3E, 0x49, 0x7E repeating, zero-extended to N.
REQ-033 Reset asserted mid-RUN or mid-DONE SHALL abort the word with no output produced.

Structure
REQ-034 Package cipher_pkg SHALL hold the state enum and the default key constants.
REQ-035 Sub-module perm_net SHALL be combinational: N/STRIDE parameters, inverse-select input, and both P and Pinv networks.

Verification
REQ-036 ROUNDS=1, K0=0x3E, encrypt din=0x02: dout = 0x36, out_valid two cycles after the handshake.
REQ-037 ROUNDS=1, K0=0x3E, decrypt din=0x36: dout = 0x02.
REQ-038 ROUNDS=3, keys all 0, encrypt 0x02: dout = 0x08; decrypt 0x08 gives 0x02.
REQ-039 Hold out_ready = 0 for 5 cycles in DONE: dout and out_valid stable, in_ready = 0, then release.
REQ-040 key_we during RUN, and key_idx = ROUNDS in IDLE: key_err pulses and the key is unchanged.
REQ-041 Reset mid-RUN: out_valid stays 0, keys return to defaults, and a new word is accepted afterwards.
